// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrgood_pkg.sv
// Shared encodings for the power-good sequencer: FSM states and fault codes.
package gf180mcu_fd_sc_mcu9t5v0__pwrgood_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_RAMP  = 2'b01,
    ST_GOOD  = 2'b10,
    ST_FAULT = 2'b11
  } pg_state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_GLITCH   = 2'b01;
  localparam logic [1:0] FC_RAILX    = 2'b10;
  localparam logic [1:0] FC_BROWNOUT = 2'b11;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrgood_cnt.sv
// Saturating up-counter with synchronous clear and a registered-count terminal match.
// Count updates one edge after clr/inc; no backpressure.
module gf180mcu_fd_sc_mcu9t5v0__pwrgood_cnt #(
  parameter int W    = 4,
  parameter int MAX  = 8,
  parameter int TERM = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         term
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == W'(TERM));

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrgood_seq.sv
// Debounces the logic-level VDD/VSS rails into PWR_GOOD with a sticky fault status.
// PWR_GOOD rises STABLE_CYCLES edges after rails go good; all outputs registered; no backpressure.
module gf180mcu_fd_sc_mcu9t5v0__pwrgood_seq
  import gf180mcu_fd_sc_mcu9t5v0__pwrgood_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int GLITCH_LIMIT  = 3,
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1),
  localparam int GL_W  = $clog2(GLITCH_LIMIT + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             VDD,
  input  logic             VSS,
  output logic             PWR_GOOD,
  output logic             FAULT,
  output logic [1:0]       FAULT_CODE,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] STABLE_CNT
);

  if (STABLE_CYCLES < 2 || GLITCH_LIMIT < 1) begin : g_bad_params
    $error("pwrgood_seq: STABLE_CYCLES must be >= 2 and GLITCH_LIMIT >= 1");
  end

  pg_state_e       state;
  logic            pwr_good;
  logic            fault;
  logic [1:0]      fault_code;
  logic            rail_x, rail_ok, rail_bad;
  logic            st_clr, st_inc, st_term;
  logic            gl_clr, gl_inc, gl_term;
  logic [CNT_W-1:0] stable_cnt;
  logic [GL_W-1:0]  glitch_cnt;
  logic            unused_ok;

  // Case-equality so an X/Z rail is reported rather than silently treated as bad.
  assign rail_x   = !((VDD === 1'b0) || (VDD === 1'b1)) ||
                    !((VSS === 1'b0) || (VSS === 1'b1));
  assign rail_ok  = (VDD === 1'b1) && (VSS === 1'b0);
  assign rail_bad = !rail_x && !rail_ok;

  always_comb begin
    st_clr = 1'b0;
    st_inc = 1'b0;
    gl_clr = 1'b0;
    gl_inc = 1'b0;
    case (state)
      ST_OFF: begin
        gl_clr = 1'b1;
        if (EN && rail_ok) st_inc = 1'b1;
        else               st_clr = 1'b1;
      end
      ST_RAMP, ST_GOOD: begin
        if (!EN) begin
          st_clr = 1'b1;
          gl_clr = 1'b1;
        end else if (rail_ok) begin
          st_inc = 1'b1;
          if (state == ST_RAMP && st_term) gl_clr = 1'b1;
        end else if (rail_bad && state == ST_RAMP) begin
          st_clr = 1'b1;
          gl_inc = 1'b1;
        end
      end
      ST_FAULT: begin
        if (!EN) begin
          st_clr = 1'b1;
          gl_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  gf180mcu_fd_sc_mcu9t5v0__pwrgood_cnt #(
    .W(CNT_W), .MAX(STABLE_CYCLES), .TERM(STABLE_CYCLES - 1)
  ) u_stable_cnt (
    .clk(CLK), .rst(RST), .clr(st_clr), .inc(st_inc), .cnt(stable_cnt), .term(st_term)
  );

  gf180mcu_fd_sc_mcu9t5v0__pwrgood_cnt #(
    .W(GL_W), .MAX(GLITCH_LIMIT), .TERM(GLITCH_LIMIT - 1)
  ) u_glitch_cnt (
    .clk(CLK), .rst(RST), .clr(gl_clr), .inc(gl_inc), .cnt(glitch_cnt), .term(gl_term)
  );

  // Only the terminal match of the glitch counter steers the FSM.
  assign unused_ok = &{1'b0, glitch_cnt};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_OFF;
      pwr_good   <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      pwr_good <= 1'b0;
      case (state)
        ST_OFF: begin
          if (EN && rail_ok) state <= ST_RAMP;
        end
        ST_RAMP: begin
          if (!EN) begin
            state <= ST_OFF;
          end else if (rail_x) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_RAILX;
          end else if (rail_bad) begin
            if (gl_term) begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= FC_GLITCH;
            end
          end else if (st_term) begin
            state    <= ST_GOOD;
            pwr_good <= 1'b1;
          end
        end
        ST_GOOD: begin
          if (!EN) begin
            state <= ST_OFF;
          end else if (rail_x) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_RAILX;
          end else if (rail_bad) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_BROWNOUT;
          end else begin
            pwr_good <= 1'b1;
          end
        end
        ST_FAULT: begin
          if (!EN) begin
            state      <= ST_OFF;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  assign PWR_GOOD   = pwr_good;
  assign FAULT      = fault;
  assign FAULT_CODE = fault_code;
  assign STATE      = state;
  assign STABLE_CNT = stable_cnt;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwrgood_seq.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares each cycle.
module tb_gf180mcu_fd_sc_mcu9t5v0__pwrgood_seq;

  localparam int SC = 16;
  localparam int GL = 3;
  localparam int CW = $clog2(SC + 1);

  logic          clk = 1'b0;
  logic          rst, en, vdd, vss;
  logic          pwr_good, fault;
  logic [1:0]    fault_code, state;
  logic [CW-1:0] stable_cnt;

  gf180mcu_fd_sc_mcu9t5v0__pwrgood_seq #(
    .STABLE_CYCLES(SC), .GLITCH_LIMIT(GL)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .VDD(vdd), .VSS(vss),
    .PWR_GOOD(pwr_good), .FAULT(fault), .FAULT_CODE(fault_code),
    .STATE(state), .STABLE_CNT(stable_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int code;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 off, 1 ramping, 2 good, 3 faulted.
  int m_st = 0, m_cnt = 0, m_gl = 0, m_code = 0;

  task automatic model_step();
    bit x, ok, bad;
    x   = !((vdd === 1'b0) || (vdd === 1'b1)) || !((vss === 1'b0) || (vss === 1'b1));
    ok  = (vdd === 1'b1) && (vss === 1'b0);
    bad = !x && !ok;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_gl = 0; m_code = 0;
    end else if (m_st == 0) begin
      if (en && ok) begin m_st = 1; m_cnt = 1; end
      else begin m_cnt = 0; m_gl = 0; end
    end else if (!en) begin
      m_st = 0; m_cnt = 0; m_gl = 0; m_code = 0;
    end else if (m_st == 1) begin
      if (x) begin m_st = 3; m_code = 2; end
      else if (bad) begin
        m_cnt = 0;
        m_gl  = m_gl + 1;
        if (m_gl == GL) begin m_st = 3; m_code = 1; end
      end else begin
        m_cnt = m_cnt + 1;
        if (m_cnt == SC) begin m_st = 2; m_gl = 0; end
      end
    end else if (m_st == 2) begin
      if (x) begin m_st = 3; m_code = 2; end
      else if (bad) begin m_st = 3; m_code = 3; end
      else m_cnt = (m_cnt + 1 > SC) ? SC : m_cnt + 1;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic v, input logic s);
    exp_t ex;
    @(negedge clk);
    rst = r; en = e; vdd = v; vss = s;
    model_step();
    ex.st   = m_st;
    ex.code = m_code;
    ex.cnt  = (m_st == 3) ? -1 : m_cnt;
    q.push_back(ex);
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (^{state, pwr_good, fault, fault_code, stable_cnt} === 1'bx) begin
          checks++;
          errors++;
          $display("FAIL unknown_output at %0t", $time);
        end
        chk("STATE", int'(state), e.st);
        chk("PWR_GOOD", int'(pwr_good), (e.st == 2) ? 1 : 0);
        chk("FAULT", int'(fault), (e.st == 3) ? 1 : 0);
        chk("FAULT_CODE", int'(fault_code), e.code);
        if (e.cnt >= 0) chk("STABLE_CNT", int'(stable_cnt), e.cnt);
      end
    end
  end

  initial begin
    int r, rr;
    logic v, s;
    rst = 1'b1; en = 1'b0; vdd = 1'b1; vss = 1'b0;
    repeat (2) drive(1, 0, 1, 0);
    // Power-up from reset, then saturation in GOOD.
    repeat (20) drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);
    // Single glitch at count 7, then full restart of the debounce window.
    repeat (7) drive(0, 1, 1, 0);
    drive(0, 1, 0, 0);
    repeat (17) drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);
    // Three glitches in RAMP latch a fault that rail recovery cannot clear.
    repeat (3) begin
      drive(0, 1, 1, 0);
      drive(0, 1, 0, 0);
    end
    repeat (5) drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);
    // X on VSS while GOOD, then EN low clears the fault.
    repeat (16) drive(0, 1, 1, 0);
    drive(0, 1, 1, 1'bx);
    repeat (2) drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);
    // Brownout coincident with EN falling resolves to OFF.
    repeat (16) drive(0, 1, 1, 0);
    drive(0, 0, 0, 0);
    // Reset while GOOD with an unknown rail.
    repeat (16) drive(0, 1, 1, 0);
    drive(1, 1, 1'bx, 0);
    drive(0, 1, 1, 0);
    // Randomized traffic, biased so GOOD and both fault kinds are reachable.
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 999);
      rr = $urandom_range(0, 99);
      v = 1'b1; s = 1'b0;
      if (rr < 4)       v = 1'b0;
      else if (rr < 6)  s = 1'b1;
      else if (rr < 7)  v = 1'bx;
      else if (rr < 8)  s = 1'bz;
      drive((r < 4) ? 1'b1 : 1'b0, (r >= 4 && r < 16) ? 1'b0 : 1'b1, v, s);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
